// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
// Build option: define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// leave it undefined for fixed priority, where port 0 always wins.
package ram_arb_pkg;

  localparam int AW_DEF     = 8;
  localparam int DW_DEF     = 26;
  localparam int RD_LAT_DEF = 1;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // One-hot strobe for a single port index.
  function automatic logic [1:0] port_mask(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way winner selection.
// RAM_ARB_ROUND_ROBIN_EN defined: on a double request, the port that did not win
// last time is chosen. Undefined: port 0 wins whenever it requests.
// The output is only meaningful when req != 0.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  output logic       winner
`ifdef RAM_ARB_ROUND_ROBIN_EN
  ,
  input  logic       last
`endif
);

  // Winner selection from the current request pair.
  always_comb begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
    if (req == 2'b11) winner = ~last;
    else              winner = req[PORT1] & ~req[PORT0];
`else
    winner = req[PORT1] & ~req[PORT0];
`endif
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port synchronous RAM.
// One access is in flight at a time: IDLE -> ISSUE -> (write) IDLE
//                                                   -> (read)  WAIT -> IDLE.
// All outputs except rdata are registered; rdata is the RAM q passed straight through.
// Build option: RAM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  output logic          ram_rden,
  input  logic [DW-1:0] ram_q
);

  // The counter only has to hold RD_LAT-1.
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    gnt_d, rvalid_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] data_d;
  logic          wren_d, rden_d;
  logic          pick;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  rr_pick2 u_pick (
    .req    (req),
    .winner (pick),
    .last   (last_q)
  );
`else
  rr_pick2 u_pick (
    .req    (req),
    .winner (pick)
  );
`endif

  assign rdata = ram_q;

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    wren_d  = 1'b0;
    rden_d  = 1'b0;
    addr_d  = ram_addr;
    data_d  = ram_data;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif

    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          sel_d   = pick;
          addr_d  = pick ? addr1  : addr0;
          data_d  = pick ? wdata1 : wdata0;
          wren_d  = we[pick];
          rden_d  = ~we[pick];
          gnt_d   = port_mask(pick);
`ifdef RAM_ARB_ROUND_ROBIN_EN
          last_d  = pick;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // The command is on the RAM pins this cycle; reads then wait out the latency.
        if (ram_rden) begin
          state_d = WAIT;
          cnt_d   = CW'(RD_LAT - 1);
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // rvalid is registered, so it is raised for the WAIT cycle whose counter reads zero,
    // which is exactly RD_LAT cycles after ISSUE.
    rvalid_d = (state_d == WAIT && cnt_d == '0) ? port_mask(sel_d) : 2'b00;
  end

  // State, counter and registered RAM command / strobe outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      cnt_q    <= '0;
      gnt      <= '0;
      rvalid   <= '0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_wren <= 1'b0;
      ram_rden <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_q   <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      gnt      <= gnt_d;
      rvalid   <= rvalid_d;
      ram_addr <= addr_d;
      ram_data <= data_d;
      ram_wren <= wren_d;
      ram_rden <= rden_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_q   <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: two instances (RD_LAT=1 and RD_LAT=2), each with a
// behavioural RAM. Expected read data comes from a shadow memory, latencies from
// the handshake timing rules, arbitration from a last-winner model.
// Honours RAM_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_ram_arbiter;

  localparam int AW = 8;
  localparam int DW = 26;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [1:0]    req      [2];
  logic [1:0]    we       [2];
  logic [AW-1:0] addr0    [2];
  logic [AW-1:0] addr1    [2];
  logic [DW-1:0] wdata0   [2];
  logic [DW-1:0] wdata1   [2];
  logic [1:0]    gnt      [2];
  logic [1:0]    rvalid   [2];
  logic [DW-1:0] rdata    [2];
  logic [AW-1:0] ram_addr [2];
  logic [DW-1:0] ram_data [2];
  logic          ram_wren [2];
  logic          ram_rden [2];
  logic [DW-1:0] ram_q    [2];

  logic [DW-1:0] shadow [2][256];
  logic          last_port [2];

  // Cycle counter, advanced on every active edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = g + 1;
    logic [DW-1:0] mem [256];
    logic [DW-1:0] q1, q2;
    logic [1:0]    gnt_prev;

    initial for (int i = 0; i < 256; i++) mem[i] = '0;

    ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req[g]),
      .we       (we[g]),
      .addr0    (addr0[g]),
      .addr1    (addr1[g]),
      .wdata0   (wdata0[g]),
      .wdata1   (wdata1[g]),
      .gnt      (gnt[g]),
      .rvalid   (rvalid[g]),
      .rdata    (rdata[g]),
      .ram_addr (ram_addr[g]),
      .ram_data (ram_data[g]),
      .ram_wren (ram_wren[g]),
      .ram_rden (ram_rden[g]),
      .ram_q    (ram_q[g])
    );

    // Synchronous RAM: registered command, q one or two cycles after issue.
    always @(posedge clk) begin
      if (ram_wren[g]) mem[ram_addr[g]] <= ram_data[g];
      if (ram_rden[g]) q1 <= mem[ram_addr[g]];
      q2 <= q1;
    end
    assign ram_q[g] = (LAT == 1) ? q1 : q2;

    // Protocol rules that hold in every cycle out of reset.
    always @(negedge clk) begin
      if (rst_n) begin
        check($sformatf("g%0d_gnt_onehot", g), ($countones(gnt[g]) <= 1), 1);
        check($sformatf("g%0d_cmd_only_with_gnt", g), (ram_wren[g] | ram_rden[g]), (gnt[g] != 2'b00));
        check($sformatf("g%0d_gnt_back_to_back", g), (gnt_prev != 2'b00 && gnt[g] != 2'b00), 0);
        check($sformatf("g%0d_gnt_with_rvalid", g), (gnt[g] != 2'b00 && rvalid[g] != 2'b00), 0);
        gnt_prev = gnt[g];
      end else begin
        gnt_prev = 2'b00;
      end
    end
  end

  // One access on instance d, port p; starts and ends just after a falling edge with the DUT idle.
  task automatic access(input int d, input bit p, input bit w,
                        input logic [AW-1:0] a, input logic [DW-1:0] dat);
    int t0, tg, tr;
    bit found;
    if (p) begin addr1[d] = a; wdata1[d] = dat; end
    else   begin addr0[d] = a; wdata0[d] = dat; end
    we[d][p]  = w;
    req[d][p] = 1'b1;
    t0 = cyc; tg = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (gnt[d] != 2'b00) begin found = 1'b1; tg = cyc; end
    end
    check("gnt_seen", found, 1);
    check("gnt_latency", tg - t0, 1);
    check("gnt_port", gnt[d], p ? 2'b10 : 2'b01);
    req[d][p] = 1'b0;
    last_port[d] = p;
    if (w) begin
      shadow[d][a] = dat;
      @(negedge clk);
    end else begin
      found = 1'b0; tr = 0;
      for (int i = 0; i < 10 && !found; i++) begin
        @(negedge clk);
        if (rvalid[d] != 2'b00) begin found = 1'b1; tr = cyc; end
      end
      check("rvalid_seen", found, 1);
      check("rvalid_latency", tr - tg, d + 1);
      check("rvalid_port", rvalid[d], p ? 2'b10 : 2'b01);
      check("rdata", rdata[d], shadow[d][a]);
      @(negedge clk);
    end
  endtask

  // Hold the requests in mask for n grants of write commands; checks winner order and spacing.
  task automatic held_grants(input int d, input logic [1:0] mask, input int n);
    int tprev, exp_p;
    bit found;
    req[d] = mask;
    tprev = cyc;
    for (int k = 0; k < n; k++) begin
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        @(negedge clk);
        if (gnt[d] != 2'b00) found = 1'b1;
      end
      check("held_gnt_seen", found, 1);
      if (mask == 2'b11) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        exp_p = last_port[d] ? 0 : 1;
`else
        exp_p = 0;
`endif
      end else begin
        exp_p = mask[1] ? 1 : 0;
      end
      check($sformatf("held_gnt_order_%0d", k), gnt[d], exp_p ? 2'b10 : 2'b01);
      check($sformatf("held_gnt_spacing_%0d", k), cyc - tprev, (k == 0) ? 1 : 2);
      tprev = cyc;
      last_port[d] = exp_p[0];
      if (we[d][exp_p]) begin
        if (exp_p != 0) shadow[d][addr1[d]] = wdata1[d];
        else            shadow[d][addr0[d]] = wdata0[d];
      end
    end
    req[d] = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    bit found;
    for (int d = 0; d < 2; d++) begin
      req[d] = '0; we[d] = '0; addr0[d] = '0; addr1[d] = '0;
      wdata0[d] = '0; wdata1[d] = '0; last_port[d] = 1'b1;
      for (int i = 0; i < 256; i++) shadow[d][i] = '0;
    end

    // Reset values.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_gnt%0d", d), gnt[d], 0);
      check($sformatf("rst_rvalid%0d", d), rvalid[d], 0);
      check($sformatf("rst_wren%0d", d), ram_wren[d], 0);
      check($sformatf("rst_rden%0d", d), ram_rden[d], 0);
      check($sformatf("rst_addr%0d", d), ram_addr[d], 0);
      check($sformatf("rst_data%0d", d), ram_data[d], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Port 0 write then read of all-ones data.
    access(0, 1'b0, 1'b1, 8'h05, 26'h3FFFFFF);
    access(0, 1'b0, 1'b0, 8'h05, '0);
    // Port 1 at the top address.
    access(0, 1'b1, 1'b1, 8'hFF, 26'h0000009);
    access(0, 1'b1, 1'b0, 8'hFF, '0);

    // Two-cycle read latency instance.
    access(1, 1'b0, 1'b1, 8'h05, 26'h2AAAAAA);
    access(1, 1'b0, 1'b0, 8'h05, '0);
    access(1, 1'b1, 1'b0, 8'hFF, '0);
    access(1, 1'b1, 1'b1, 8'h00, 26'h1555555);
    access(1, 1'b0, 1'b0, 8'h00, '0);

    // A single requester holding req through gnt is re-served two cycles later.
    addr1[1] = 8'h40; wdata1[1] = 26'h0001234; we[1] = 2'b10;
    held_grants(1, 2'b10, 3);
    access(1, 1'b0, 1'b0, 8'h40, '0);

    // Random traffic on both instances.
    for (int n = 0; n < 60; n++) begin
      int d;
      bit p, w;
      logic [AW-1:0] a;
      logic [DW-1:0] dat;
      d   = $urandom_range(0, 1);
      p   = 1'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      dat = DW'($urandom);
      access(d, p, w, a, dat);
    end

    // Double request from reset: arbitration order.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_port[0] = 1'b1;
    last_port[1] = 1'b1;
    @(negedge clk);
    addr0[0] = 8'h10; wdata0[0] = 26'h0ABCDEF;
    addr1[0] = 8'h11; wdata1[0] = 26'h0123456;
    we[0] = 2'b11;
    held_grants(0, 2'b11, 4);
    access(0, 1'b0, 1'b0, 8'h10, '0);
    access(0, 1'b1, 1'b0, 8'h11, '0);

    // Reset in the middle of a read: outputs clear at once, the read is dropped.
    we[0] = 2'b00; addr0[0] = 8'h10;
    req[0] = 2'b01;
    t0 = cyc; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (gnt[0] != 2'b00) found = 1'b1;
    end
    check("midread_gnt_seen", found, 1);
    check("midread_gnt_latency", cyc - t0, 1);
    req[0] = 2'b00;
    @(posedge clk);
    #1;
    check("midread_in_wait_rvalid", rvalid[0], 2'b01);
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", gnt[0], 0);
    check("async_rst_rvalid", rvalid[0], 0);
    check("async_rst_wren", ram_wren[0], 0);
    check("async_rst_rden", ram_rden[0], 0);
    check("async_rst_addr", ram_addr[0], 0);
    check("async_rst_data", ram_data[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_port[0] = 1'b1;
    last_port[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_no_rvalid_%0d", i), rvalid[0], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
